// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port ram.
// The slave view belongs to the arbiter, the master view to the requester/ram side.
interface ram_arbiter_if;
  logic        a_req;
  logic        a_wr;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_err;
  logic [31:0] a_rdata;
  logic        b_req;
  logic        b_wr;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic        b_err;
  logic [31:0] b_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic        ram_rd;
  logic [31:0] ram_rdata;
  logic        busy;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_wr, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output ram_addr, ram_wr, ram_wdata, ram_rd,
    input  ram_rdata,
    output busy
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_wr, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  ram_addr, ram_wr, ram_wdata, ram_rd,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port registered-read ram.
// One access per three cycles: IDLE (grant) -> ISSUE (strobe) -> CAPTURE (data).
module ram_arbiter #(
  parameter int DEPTH   = 256,
  parameter bit RR_MODE = 1'b1
) (
  input logic         clock,
  input logic         reset,
  ram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]  state;
  logic        own_b;
  logic        op_wr;
  logic        op_err;
  logic        last_b;

  logic        pick_b;
  logic        sel_wr;
  logic        sel_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Round-robin gives a tie to whoever was not served last.
  always_comb begin
    if (RR_MODE)
      pick_b = bus.b_req & (~bus.a_req | ~last_b);
    else
      pick_b = ~bus.a_req;
    sel_wr    = pick_b ? bus.b_wr    : bus.a_wr;
    sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    sel_err   = sel_addr >= 32'(DEPTH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      own_b         <= 1'b0;
      op_wr         <= 1'b0;
      op_err        <= 1'b0;
      last_b        <= 1'b1;
      bus.a_ack     <= 1'b0;
      bus.a_err     <= 1'b0;
      bus.a_rdata   <= 32'h0;
      bus.b_ack     <= 1'b0;
      bus.b_err     <= 1'b0;
      bus.b_rdata   <= 32'h0;
      bus.ram_addr  <= 32'h0;
      bus.ram_wr    <= 1'b0;
      bus.ram_wdata <= 32'h0;
      bus.ram_rd    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.a_ack <= 1'b0;
      bus.a_err <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.b_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.a_req | bus.b_req) begin
            own_b         <= pick_b;
            op_wr         <= sel_wr;
            op_err        <= sel_err;
            last_b        <= pick_b;
            bus.ram_addr  <= sel_addr;
            bus.ram_wdata <= sel_wr ? sel_wdata : 32'h0;
            bus.ram_wr    <= sel_wr & ~sel_err;
            bus.ram_rd    <= ~sel_wr & ~sel_err;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.ram_wr <= 1'b0;
          bus.ram_rd <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          if (own_b) begin
            bus.b_ack   <= 1'b1;
            bus.b_err   <= op_err;
            bus.b_rdata <= (~op_wr & ~op_err) ? bus.ram_rdata : 32'h0;
          end else begin
            bus.a_ack   <= 1'b1;
            bus.a_err   <= op_err;
            bus.a_rdata <= (~op_wr & ~op_err) ? bus.ram_rdata : 32'h0;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed cases plus random two-port traffic
// checked against a grant-order/memory model.
module tb_ram_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_arbiter_if r ();
  ram_arbiter_if f ();

  ram_arbiter #(.DEPTH(256), .RR_MODE(1'b1)) u_rr (
    .clock(clock), .reset(reset), .bus(r.slave)
  );
  ram_arbiter #(.DEPTH(256), .RR_MODE(1'b0)) u_fp (
    .clock(clock), .reset(reset), .bus(f.slave)
  );

  // ram emulation: write on strobe, registered read data
  logic [31:0] ram_r [256] = '{default: 32'h0};
  always @(posedge clock) begin
    if (r.ram_wr) ram_r[r.ram_addr[7:0]] <= r.ram_wdata;
    if (r.ram_rd) r.ram_rdata <= ram_r[r.ram_addr[7:0]];
  end
  assign f.ram_rdata = 32'h0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_mem [256];
  bit last_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_r(output int port, output int lat);
    port = -1;
    lat  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      lat++;
      if (r.a_ack || r.b_ack) begin
        port = (r.a_ack && r.b_ack) ? 2 : (r.b_ack ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic wait_f(output int port, output int lat);
    port = -1;
    lat  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      lat++;
      if (f.a_ack || f.b_ack) begin
        port = (f.a_ack && f.b_ack) ? 2 : (f.b_ack ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic check_op(input int p, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    logic [31:0] exp_rd;
    err    = addr >= 32'd256;
    exp_rd = (!wr && !err) ? exp_mem[addr[7:0]] : 32'h0;
    chk("err", 32'(p == 1 ? r.b_err : r.a_err), 32'(err));
    chk("rdata", p == 1 ? r.b_rdata : r.a_rdata, exp_rd);
    if (wr && !err) exp_mem[addr[7:0]] = wdata;
    last_b = (p == 1);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom % 8 == 0) return 32'h100 + 32'($urandom % 64);
    return 32'($urandom % 16);
  endfunction

  initial begin
    int p, lat, seen;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    reset = 1'b1;
    {r.a_req, r.a_wr, r.b_req, r.b_wr} = '0;
    {r.a_addr, r.a_wdata, r.b_addr, r.b_wdata} = '0;
    {f.a_req, f.a_wr, f.b_req, f.b_wr} = '0;
    {f.a_addr, f.a_wdata, f.b_addr, f.b_wdata} = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(r.busy), 0);
    chk("rst_ram_addr", r.ram_addr, 0);
    chk("rst_a_ack", 32'(r.a_ack), 0);
    chk("rst_a_rdata", r.a_rdata, 0);
    reset  = 1'b0;
    last_b = 1'b1;

    // fixed priority: A always wins while requesting
    f.a_req = 1; f.b_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_f(p, lat);
      chk("fp_a_wins", p, 0);
      chk("fp_lat", lat, 3);
    end
    f.a_req = 0;
    wait_f(p, lat);
    chk("fp_b_after", p, 1);
    chk("fp_b_lat", lat, 3);
    f.b_req = 0;

    // round robin with both reads held high
    r.a_req = 1; r.a_addr = 3;
    r.b_req = 1; r.b_addr = 4;
    for (int k = 0; k < 4; k++) begin
      wait_r(p, lat);
      chk("rr_alt", p, k % 2);
      chk("rr_lat", lat, 3);
      check_op(k % 2, 1'b0, k % 2 ? 32'd4 : 32'd3, 32'h0);
    end
    r.a_req = 0; r.b_req = 0;
    @(negedge clock);

    // A write then pipelined A read of the same word
    r.a_req = 1; r.a_wr = 1; r.a_addr = 5; r.a_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("wr_strobe", 32'(r.ram_wr), 1);
    chk("wr_addr", r.ram_addr, 5);
    chk("wr_data", r.ram_wdata, 32'hDEAD_BEEF);
    chk("wr_busy", 32'(r.busy), 1);
    @(negedge clock);
    chk("wr_strobe_off", 32'(r.ram_wr), 0);
    @(negedge clock);
    chk("wr_ack", 32'(r.a_ack), 1);
    check_op(0, 1'b1, 5, 32'hDEAD_BEEF);
    r.a_wr = 0;
    wait_r(p, lat);
    chk("rd_port", p, 0);
    chk("rd_lat", lat, 3);
    check_op(0, 1'b0, 5, 0);
    r.a_req = 0;
    @(negedge clock);

    // B out-of-range read
    r.b_req = 1; r.b_wr = 0; r.b_addr = 32'h100;
    @(negedge clock);
    chk("oor_rd", 32'(r.ram_rd), 0);
    chk("oor_wr", 32'(r.ram_wr), 0);
    wait_r(p, lat);
    chk("oor_port", p, 1);
    chk("oor_lat", lat, 2);
    check_op(1, 1'b0, 32'h100, 0);
    r.b_req = 0;
    @(negedge clock);

    // reset while a read is in ISSUE
    r.a_req = 1; r.a_wr = 0; r.a_addr = 5;
    @(negedge clock);
    chk("pre_rst_rd", 32'(r.ram_rd), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rd", 32'(r.ram_rd), 0);
    chk("mid_rst_busy", 32'(r.busy), 0);
    chk("mid_rst_addr", r.ram_addr, 0);
    chk("mid_rst_rdata", r.a_rdata, 0);
    r.a_req = 0;
    @(negedge clock);
    reset  = 1'b0;
    last_b = 1'b1;
    seen   = 0;
    repeat (5) begin
      @(negedge clock);
      if (r.a_ack || r.b_ack) seen++;
    end
    chk("no_ack_after_rst", seen, 0);
    r.a_req = 1;
    wait_r(p, lat);
    chk("post_rst_port", p, 0);
    chk("post_rst_lat", lat, 3);
    check_op(0, 1'b0, 5, 0);
    r.a_req = 0;
    @(negedge clock);

    // random two-port traffic
    for (int it = 0; it < 40; it++) begin
      bit aon, bon, aw, bw;
      logic [31:0] aa, ba, ad, bd;
      int first;
      aon = 1'($urandom % 2);
      bon = 1'($urandom % 2);
      if (!aon && !bon) aon = 1;
      aw = 1'($urandom % 2); aa = rand_addr(); ad = $urandom;
      bw = 1'($urandom % 2); ba = rand_addr(); bd = $urandom;
      first = (aon && bon) ? (last_b ? 0 : 1) : (aon ? 0 : 1);
      r.a_req = aon; r.a_wr = aw; r.a_addr = aa; r.a_wdata = ad;
      r.b_req = bon; r.b_wr = bw; r.b_addr = ba; r.b_wdata = bd;
      wait_r(p, lat);
      chk("rand_grant", p, first);
      chk("rand_lat", lat, 3);
      if (first == 0) begin
        check_op(0, aw, aa, ad);
        r.a_req = 0;
      end else begin
        check_op(1, bw, ba, bd);
        r.b_req = 0;
      end
      if (aon && bon) begin
        wait_r(p, lat);
        chk("rand_grant2", p, 1 - first);
        chk("rand_lat2", lat, 3);
        if (first == 0) check_op(1, bw, ba, bd);
        else            check_op(0, aw, aa, ad);
        r.a_req = 0;
        r.b_req = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
